// File: rtl/cva6_icache_axi_refill_pkg.sv
// Shared types, AXI constants and helper functions for the I$ AXI refill engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cva6_icache_axi_refill_pkg;

    // Upper bound on refill slots; the free-slot picker works on this width.
    localparam int unsigned ICACHE_MAX_SLOTS = 8;

    // AXI encodings used on the AR channel.
    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [3:0] AXI_CACHE_CACHED = 4'b1111;
    localparam logic [3:0] AXI_CACHE_NC     = 4'b0000;

    // Default configuration, used to size the reference structs below.
    localparam int unsigned DEF_LINE_WIDTH     = 128;
    localparam int unsigned DEF_AXI_DATA_WIDTH = 64;
    localparam int unsigned DEF_PADDR_WIDTH    = 56;
    localparam int unsigned DEF_TID_WIDTH      = 2;

    // Number of R beats needed to fill one I$ line.
    function automatic int unsigned ICACHE_REFILL_BEATS(input int unsigned line_width,
                                                        input int unsigned axi_data_width);
        return line_width / axi_data_width;
    endfunction

    localparam int unsigned DEF_BEAT_CNT_WIDTH =
        $clog2(ICACHE_REFILL_BEATS(DEF_LINE_WIDTH, DEF_AXI_DATA_WIDTH)) + 1;

    // Lowest set bit index of an 8-bit vector (0 when empty; caller checks emptiness).
    function automatic logic [2:0] lowest_set(input logic [ICACHE_MAX_SLOTS-1:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = ICACHE_MAX_SLOTS - 1; i >= 0; i--) begin
            if (vec[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // One refill slot's architectural state in the default configuration.
    typedef struct packed {
        logic                          valid;
        logic                          killed;
        logic                          nc;
        logic [DEF_TID_WIDTH-1:0]      tid;
        logic [DEF_BEAT_CNT_WIDTH-1:0] beat_cnt;
        logic                          err;
        logic [DEF_LINE_WIDTH-1:0]     data;
    } refill_slot_t;

    // Miss request as seen from the I$ in the default configuration.
    typedef struct packed {
        logic [DEF_PADDR_WIDTH-1:0] paddr;
        logic                       nc;
        logic [DEF_TID_WIDTH-1:0]   tid;
    } icache_refill_req_t;

    // Line return towards the I$ in the default configuration.
    typedef struct packed {
        logic [DEF_LINE_WIDTH-1:0] data;
        logic [DEF_TID_WIDTH-1:0]  tid;
        logic                      err;
    } icache_refill_rtrn_t;

endpackage

// File: rtl/cva6_icache_axi_refill_slot.sv
// One refill slot: captures R beats of its AXI ID into a line buffer, counts beats, ORs errors.
// Latency: beat stored at the accepting edge; done_o/line_o/err_o include the current beat combinationally.
// Backpressure: none here; the parent only presents beats it has accepted.
module cva6_icache_refill_slot
    import cva6_icache_axi_refill_pkg::*;
#(
    parameter int unsigned LineWidth    = 128,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned TidWidth     = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    alloc_i,
    input  logic                    alloc_nc_i,
    input  logic [TidWidth-1:0]     alloc_tid_i,
    input  logic                    kill_i,
    input  logic                    beat_i,
    input  logic [AxiDataWidth-1:0] beat_data_i,
    input  logic                    beat_err_i,
    input  logic                    beat_last_i,
    output logic                    valid_o,
    output logic [TidWidth-1:0]     tid_o,
    output logic                    done_o,
    output logic [LineWidth-1:0]    line_o,
    output logic                    err_o
);
    localparam int unsigned Beats = ICACHE_REFILL_BEATS(LineWidth, AxiDataWidth);
    localparam int unsigned CntW  = $clog2(Beats) + 1;

    logic                 valid_q, valid_d;
    logic                 killed_q, killed_d;
    logic                 nc_q, nc_d;
    logic [TidWidth-1:0]  tid_q, tid_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [LineWidth-1:0] data_q, data_d;
    int                   widx;

    // Next-state: allocate a free slot, or update a busy one with kill and accepted beats.
    always_comb begin
        valid_d  = valid_q;
        killed_d = killed_q;
        nc_d     = nc_q;
        tid_d    = tid_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        data_d   = data_q;
        // Uncached fetches always land in word 0; a count past the line drops the beat.
        widx     = nc_q ? 0 : int'(cnt_q);
        if (alloc_i && !valid_q) begin
            valid_d  = 1'b1;
            killed_d = 1'b0;
            nc_d     = alloc_nc_i;
            tid_d    = alloc_tid_i;
            cnt_d    = '0;
            err_d    = 1'b0;
            data_d   = '0;
        end
        if (valid_q) begin
            if (kill_i) killed_d = 1'b1;
            if (beat_i) begin
                for (int w = 0; w < int'(Beats); w++) begin
                    if (w == widx) data_d[w*AxiDataWidth +: AxiDataWidth] = beat_data_i;
                end
                if (cnt_q != CntW'(Beats)) cnt_d = cnt_q + CntW'(1);
                err_d = err_q | beat_err_i;
                if (beat_last_i) valid_d = 1'b0;
            end
        end
    end

    // Slot state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q  <= 1'b0;
            killed_q <= 1'b0;
            nc_q     <= 1'b0;
            tid_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            killed_q <= killed_d;
            nc_q     <= nc_d;
            tid_q    <= tid_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            data_q   <= data_d;
        end
    end

    // A kill arriving with the last beat still suppresses the return.
    assign done_o  = valid_q & beat_i & beat_last_i & ~killed_q & ~kill_i;
    assign valid_o = valid_q;
    assign tid_o   = tid_q;
    assign line_o  = data_d;
    assign err_o   = err_d;

endmodule

// File: rtl/cva6_icache_axi_refill.sv
// Read-only AXI refill engine: I$ misses -> AR bursts (one ID per slot) -> reassembled line returns.
// Latency: AR valid 1 cycle after accept; return valid 1 cycle after the last R beat.
// Backpressure: req_ready_o needs a free slot and a free AR register; r_ready_o drops while the return register is held.
module cva6_icache_axi_refill
    import cva6_icache_axi_refill_pkg::*;
#(
    parameter int unsigned LineWidth      = 128,
    parameter int unsigned AxiDataWidth   = 64,
    parameter int unsigned AxiAddrWidth   = 64,
    parameter int unsigned AxiIdWidth     = 4,
    parameter int unsigned PAddrWidth     = 56,
    parameter int unsigned TidWidth       = 2,
    parameter int unsigned NumOutstanding = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [PAddrWidth-1:0]   req_paddr_i,
    input  logic                    req_nc_i,
    input  logic [TidWidth-1:0]     req_tid_i,
    input  logic                    kill_i,
    output logic                    rtrn_valid_o,
    input  logic                    rtrn_ready_i,
    output logic [LineWidth-1:0]    rtrn_data_o,
    output logic [TidWidth-1:0]     rtrn_tid_o,
    output logic                    rtrn_err_o,
    output logic                    busy_o,
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    output logic [AxiAddrWidth-1:0] ar_addr_o,
    output logic [7:0]              ar_len_o,
    output logic [2:0]              ar_size_o,
    output logic [1:0]              ar_burst_o,
    output logic [AxiIdWidth-1:0]   ar_id_o,
    output logic [3:0]              ar_cache_o,
    input  logic                    r_valid_i,
    output logic                    r_ready_o,
    input  logic [AxiDataWidth-1:0] r_data_i,
    input  logic [1:0]              r_resp_i,
    input  logic                    r_last_i,
    input  logic [AxiIdWidth-1:0]   r_id_i
);
    localparam int unsigned Beats = ICACHE_REFILL_BEATS(LineWidth, AxiDataWidth);
    localparam int unsigned IdxW  = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam logic [AxiAddrWidth-1:0] LineMask = ~AxiAddrWidth'(LineWidth / 8 - 1);
    localparam logic [AxiAddrWidth-1:0] WordMask = ~AxiAddrWidth'(AxiDataWidth / 8 - 1);
    localparam logic [7:0]              LineLen  = 8'(Beats - 1);
    localparam logic [2:0]              BeatSize = 3'($clog2(AxiDataWidth / 8));

    logic [NumOutstanding-1:0] slot_valid, slot_alloc, slot_beat, slot_done, slot_err;
    logic [TidWidth-1:0]       slot_tid  [NumOutstanding];
    logic [LineWidth-1:0]      slot_line [NumOutstanding];

    logic [ICACHE_MAX_SLOTS-1:0] free_vec;
    logic                        any_free;
    logic [IdxW-1:0]             alloc_idx;
    logic                        req_accept;
    logic                        r_beat;
    logic                        id_hit;
    logic [AxiAddrWidth-1:0]     paddr_ext;

    logic                    ar_valid_q, ar_valid_d;
    logic [AxiAddrWidth-1:0] ar_addr_q, ar_addr_d;
    logic [7:0]              ar_len_q, ar_len_d;
    logic [2:0]              ar_size_q, ar_size_d;
    logic [1:0]              ar_burst_q, ar_burst_d;
    logic [AxiIdWidth-1:0]   ar_id_q, ar_id_d;
    logic [3:0]              ar_cache_q, ar_cache_d;

    logic                 rtrn_valid_q, rtrn_valid_d;
    logic [LineWidth-1:0] rtrn_data_q, rtrn_data_d;
    logic [TidWidth-1:0]  rtrn_tid_q, rtrn_tid_d;
    logic                 rtrn_err_q, rtrn_err_d;

    // Pick the lowest free slot; a slot closing this cycle only becomes free next cycle.
    always_comb begin
        free_vec                   = '0;
        free_vec[NumOutstanding-1:0] = ~slot_valid;
        any_free                   = |free_vec;
        alloc_idx                  = IdxW'(lowest_set(free_vec));
    end

    assign req_ready_o = any_free & (~ar_valid_q | ar_ready_i);
    assign req_accept  = req_valid_i & req_ready_o;
    assign r_ready_o   = ~rtrn_valid_q | rtrn_ready_i;
    assign r_beat      = r_valid_i & r_ready_o;
    assign id_hit      = |(slot_beat & slot_valid);
    assign paddr_ext   = AxiAddrWidth'(req_paddr_i);

    for (genvar k = 0; k < NumOutstanding; k++) begin : g_slot
        assign slot_alloc[k] = req_accept & (alloc_idx == IdxW'(k));
        assign slot_beat[k]  = r_beat & (r_id_i == AxiIdWidth'(k));

        cva6_icache_refill_slot #(
            .LineWidth    (LineWidth),
            .AxiDataWidth (AxiDataWidth),
            .TidWidth     (TidWidth)
        ) i_slot (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .alloc_i     (slot_alloc[k]),
            .alloc_nc_i  (req_nc_i),
            .alloc_tid_i (req_tid_i),
            .kill_i      (kill_i),
            .beat_i      (slot_beat[k]),
            .beat_data_i (r_data_i),
            .beat_err_i  (r_resp_i[1]),
            .beat_last_i (r_last_i),
            .valid_o     (slot_valid[k]),
            .tid_o       (slot_tid[k]),
            .done_o      (slot_done[k]),
            .line_o      (slot_line[k]),
            .err_o       (slot_err[k])
        );
    end

    // AR request register: loaded on accept, held until the slave takes it.
    always_comb begin
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        ar_id_d    = ar_id_q;
        ar_cache_d = ar_cache_q;
        if (ar_ready_i) ar_valid_d = 1'b0;
        if (req_accept) begin
            ar_valid_d = 1'b1;
            ar_addr_d  = paddr_ext & (req_nc_i ? WordMask : LineMask);
            ar_len_d   = req_nc_i ? 8'd0 : LineLen;
            ar_size_d  = BeatSize;
            ar_burst_d = AXI_BURST_INCR;
            ar_id_d    = AxiIdWidth'(alloc_idx);
            ar_cache_d = req_nc_i ? AXI_CACHE_NC : AXI_CACHE_CACHED;
        end
    end

    // Return register: at most one slot completes per cycle since R carries one beat.
    always_comb begin
        rtrn_valid_d = rtrn_valid_q;
        rtrn_data_d  = rtrn_data_q;
        rtrn_tid_d   = rtrn_tid_q;
        rtrn_err_d   = rtrn_err_q;
        if (rtrn_ready_i) rtrn_valid_d = 1'b0;
        for (int k = 0; k < int'(NumOutstanding); k++) begin
            if (slot_done[k]) begin
                rtrn_valid_d = 1'b1;
                rtrn_data_d  = slot_line[k];
                rtrn_tid_d   = slot_tid[k];
                rtrn_err_d   = slot_err[k];
            end
        end
    end

    // AR and return registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ar_valid_q   <= 1'b0;
            ar_addr_q    <= '0;
            ar_len_q     <= '0;
            ar_size_q    <= '0;
            ar_burst_q   <= '0;
            ar_id_q      <= '0;
            ar_cache_q   <= '0;
            rtrn_valid_q <= 1'b0;
            rtrn_data_q  <= '0;
            rtrn_tid_q   <= '0;
            rtrn_err_q   <= 1'b0;
        end else begin
            ar_valid_q   <= ar_valid_d;
            ar_addr_q    <= ar_addr_d;
            ar_len_q     <= ar_len_d;
            ar_size_q    <= ar_size_d;
            ar_burst_q   <= ar_burst_d;
            ar_id_q      <= ar_id_d;
            ar_cache_q   <= ar_cache_d;
            rtrn_valid_q <= rtrn_valid_d;
            rtrn_data_q  <= rtrn_data_d;
            rtrn_tid_q   <= rtrn_tid_d;
            rtrn_err_q   <= rtrn_err_d;
        end
    end

`ifndef SYNTHESIS
    // An R beat must belong to a slot that is waiting for data.
    always_ff @(posedge clk_i) begin
        if (rst_ni && r_beat) begin
            assert (id_hit) else $error("R beat for idle AXI ID %0d dropped", r_id_i);
        end
    end
`endif

    assign busy_o       = (|slot_valid) | ar_valid_q;
    assign ar_valid_o   = ar_valid_q;
    assign ar_addr_o    = ar_addr_q;
    assign ar_len_o     = ar_len_q;
    assign ar_size_o    = ar_size_q;
    assign ar_burst_o   = ar_burst_q;
    assign ar_id_o      = ar_id_q;
    assign ar_cache_o   = ar_cache_q;
    assign rtrn_valid_o = rtrn_valid_q;
    assign rtrn_data_o  = rtrn_data_q;
    assign rtrn_tid_o   = rtrn_tid_q;
    assign rtrn_err_o   = rtrn_err_q;

endmodule

// File: tb/tb_cva6_icache_axi_refill.sv
// Directed bench for the I$ AXI refill engine: a 128/64 instance and a 256/64 instance.
// Latency: n/a.
// Backpressure: exercised through rtrn_ready and ar_ready stalls.
module tb_cva6_icache_axi_refill;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: 128-bit line, 64-bit AXI
    logic         req_valid, req_ready, req_nc, kill;
    logic [55:0]  req_paddr;
    logic [1:0]   req_tid;
    logic         rtrn_valid, rtrn_ready, rtrn_err, busy;
    logic [127:0] rtrn_data;
    logic [1:0]   rtrn_tid;
    logic         ar_valid, ar_ready;
    logic [63:0]  ar_addr;
    logic [7:0]   ar_len;
    logic [2:0]   ar_size;
    logic [1:0]   ar_burst;
    logic [3:0]   ar_id, ar_cache;
    logic         r_valid, r_ready, r_last;
    logic [63:0]  r_data;
    logic [1:0]   r_resp;
    logic [3:0]   r_id;

    // Instance B: 256-bit line, 64-bit AXI
    logic         b_req_valid, b_req_ready, b_req_nc, b_kill;
    logic [55:0]  b_req_paddr;
    logic [1:0]   b_req_tid;
    logic         b_rtrn_valid, b_rtrn_ready, b_rtrn_err, b_busy;
    logic [255:0] b_rtrn_data;
    logic [1:0]   b_rtrn_tid;
    logic         b_ar_valid, b_ar_ready;
    logic [63:0]  b_ar_addr;
    logic [7:0]   b_ar_len;
    logic [2:0]   b_ar_size;
    logic [1:0]   b_ar_burst;
    logic [3:0]   b_ar_id, b_ar_cache;
    logic         b_r_valid, b_r_ready, b_r_last;
    logic [63:0]  b_r_data;
    logic [1:0]   b_r_resp;
    logic [3:0]   b_r_id;

    cva6_icache_axi_refill dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_paddr_i(req_paddr),
        .req_nc_i(req_nc), .req_tid_i(req_tid), .kill_i(kill),
        .rtrn_valid_o(rtrn_valid), .rtrn_ready_i(rtrn_ready), .rtrn_data_o(rtrn_data),
        .rtrn_tid_o(rtrn_tid), .rtrn_err_o(rtrn_err), .busy_o(busy),
        .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr), .ar_len_o(ar_len),
        .ar_size_o(ar_size), .ar_burst_o(ar_burst), .ar_id_o(ar_id), .ar_cache_o(ar_cache),
        .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data), .r_resp_i(r_resp),
        .r_last_i(r_last), .r_id_i(r_id)
    );

    cva6_icache_axi_refill #(.LineWidth(256)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_paddr_i(b_req_paddr),
        .req_nc_i(b_req_nc), .req_tid_i(b_req_tid), .kill_i(b_kill),
        .rtrn_valid_o(b_rtrn_valid), .rtrn_ready_i(b_rtrn_ready), .rtrn_data_o(b_rtrn_data),
        .rtrn_tid_o(b_rtrn_tid), .rtrn_err_o(b_rtrn_err), .busy_o(b_busy),
        .ar_valid_o(b_ar_valid), .ar_ready_i(b_ar_ready), .ar_addr_o(b_ar_addr), .ar_len_o(b_ar_len),
        .ar_size_o(b_ar_size), .ar_burst_o(b_ar_burst), .ar_id_o(b_ar_id), .ar_cache_o(b_ar_cache),
        .r_valid_i(b_r_valid), .r_ready_o(b_r_ready), .r_data_i(b_r_data), .r_resp_i(b_r_resp),
        .r_last_i(b_r_last), .r_id_i(b_r_id)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [55:0] pa, input logic nc, input logic [1:0] tid);
        req_valid = 1'b1; req_paddr = pa; req_nc = nc; req_tid = tid;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic beat(input logic [3:0] id, input logic [63:0] d, input logic last);
        r_valid = 1'b1; r_id = id; r_data = d; r_last = last; r_resp = 2'b00;
        tick();
        r_valid = 1'b0; r_last = 1'b0;
    endtask

    task automatic b_beat(input logic [63:0] d, input logic [1:0] resp, input logic last);
        b_r_valid = 1'b1; b_r_id = 4'd0; b_r_data = d; b_r_last = last; b_r_resp = resp;
        tick();
        b_r_valid = 1'b0; b_r_last = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_paddr = '0; req_nc = 0; req_tid = '0; kill = 0;
        rtrn_ready = 1; ar_ready = 0;
        r_valid = 0; r_data = '0; r_resp = '0; r_last = 0; r_id = '0;
        b_req_valid = 0; b_req_paddr = '0; b_req_nc = 0; b_req_tid = '0; b_kill = 0;
        b_rtrn_ready = 1; b_ar_ready = 1;
        b_r_valid = 0; b_r_data = '0; b_r_resp = '0; b_r_last = 0; b_r_id = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;

        // reset state
        chk("rst_ar_valid",   256'(ar_valid),   256'(1'b0));
        chk("rst_ar_addr",    256'(ar_addr),    256'(64'h0));
        chk("rst_rtrn_valid", 256'(rtrn_valid), 256'(1'b0));
        chk("rst_r_ready",    256'(r_ready),    256'(1'b1));
        chk("rst_busy",       256'(busy),       256'(1'b0));
        chk("rst_req_ready",  256'(req_ready),  256'(1'b1));

        // cached line fill, 128/64
        req(56'h8000_0038, 1'b0, 2'd1);
        chk("fill_ar_valid", 256'(ar_valid), 256'(1'b1));
        chk("fill_ar_addr",  256'(ar_addr),  256'(64'h8000_0030));
        chk("fill_ar_len",   256'(ar_len),   256'(8'd1));
        chk("fill_ar_size",  256'(ar_size),  256'(3'd3));
        chk("fill_ar_burst", 256'(ar_burst), 256'(2'b01));
        chk("fill_ar_cache", 256'(ar_cache), 256'(4'hF));
        chk("fill_ar_id",    256'(ar_id),    256'(4'd0));
        chk("fill_busy",     256'(busy),     256'(1'b1));
        ar_ready = 1'b1;
        tick();
        chk("fill_ar_drop", 256'(ar_valid), 256'(1'b0));
        beat(4'd0, 64'hAAAA_1111_2222_3333, 1'b0);
        chk("fill_no_early_rtrn", 256'(rtrn_valid), 256'(1'b0));
        beat(4'd0, 64'hBBBB_4444_5555_6666, 1'b1);
        chk("fill_rtrn_valid", 256'(rtrn_valid), 256'(1'b1));
        chk("fill_rtrn_data",  256'(rtrn_data),  256'({64'hBBBB_4444_5555_6666, 64'hAAAA_1111_2222_3333}));
        chk("fill_rtrn_tid",   256'(rtrn_tid),   256'(2'd1));
        chk("fill_rtrn_err",   256'(rtrn_err),   256'(1'b0));
        tick();
        chk("fill_rtrn_clr", 256'(rtrn_valid), 256'(1'b0));
        chk("fill_idle",     256'(busy),       256'(1'b0));

        // uncached single-beat fetch
        req(56'h1004, 1'b1, 2'd2);
        chk("nc_ar_addr",  256'(ar_addr),  256'(64'h1000));
        chk("nc_ar_len",   256'(ar_len),   256'(8'd0));
        chk("nc_ar_cache", 256'(ar_cache), 256'(4'h0));
        chk("nc_ar_id",    256'(ar_id),    256'(4'd0));
        beat(4'd0, 64'hDDDD_0000_1234_5678, 1'b1);
        chk("nc_rtrn_data", 256'(rtrn_data), 256'({64'h0, 64'hDDDD_0000_1234_5678}));
        chk("nc_rtrn_tid",  256'(rtrn_tid),  256'(2'd2));
        tick();

        // two fills, interleaved R beats
        req(56'h2000, 1'b0, 2'd0);
        req(56'h3040, 1'b0, 2'd3);
        chk("il_ar_id",   256'(ar_id),   256'(4'd1));
        chk("il_ar_addr", 256'(ar_addr), 256'(64'h3040));
        beat(4'd1, 64'hC0C0_C0C0_C0C0_C0C0, 1'b0);
        beat(4'd0, 64'hD0D0_D0D0_D0D0_D0D0, 1'b0);
        beat(4'd1, 64'hC1C1_C1C1_C1C1_C1C1, 1'b1);
        chk("il_rtrn1_data", 256'(rtrn_data), 256'({64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0}));
        chk("il_rtrn1_tid",  256'(rtrn_tid),  256'(2'd3));
        beat(4'd0, 64'hD1D1_D1D1_D1D1_D1D1, 1'b1);
        chk("il_rtrn0_valid", 256'(rtrn_valid), 256'(1'b1));
        chk("il_rtrn0_data",  256'(rtrn_data),  256'({64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0}));
        chk("il_rtrn0_tid",   256'(rtrn_tid),   256'(2'd0));
        tick();

        // kill while slot 0 is mid-burst, with a new request in the same cycle
        req(56'h4000, 1'b0, 2'd1);
        beat(4'd0, 64'h0000_0000_0000_00E0, 1'b0);
        kill = 1'b1;
        req(56'h5000, 1'b0, 2'd2);
        kill = 1'b0;
        chk("kill_new_id", 256'(ar_id), 256'(4'd1));
        beat(4'd0, 64'h0000_0000_0000_00E1, 1'b1);
        chk("kill_silent", 256'(rtrn_valid), 256'(1'b0));
        chk("kill_busy",   256'(busy),       256'(1'b1));
        beat(4'd1, 64'h1111_0000_0000_0000, 1'b0);
        beat(4'd1, 64'h2222_0000_0000_0000, 1'b1);
        chk("kill_new_valid", 256'(rtrn_valid), 256'(1'b1));
        chk("kill_new_data",  256'(rtrn_data),  256'({64'h2222_0000_0000_0000, 64'h1111_0000_0000_0000}));
        chk("kill_new_tid",   256'(rtrn_tid),   256'(2'd2));
        tick();
        chk("kill_idle", 256'(busy), 256'(1'b0));

        // return backpressure holds R off without losing data
        rtrn_ready = 1'b0;
        req(56'h6000, 1'b0, 2'd1);
        req(56'h7000, 1'b0, 2'd2);
        beat(4'd0, 64'h5050_5050_0000_0000, 1'b0);
        beat(4'd0, 64'h5151_5151_0000_0000, 1'b1);
        r_valid = 1'b1; r_id = 4'd1; r_data = 64'h9090_0000_0000_9090; r_last = 1'b0;
        #1;
        chk("bp_r_ready_low", 256'(r_ready), 256'(1'b0));
        repeat (5) tick();
        chk("bp_rtrn_held",  256'(rtrn_valid), 256'(1'b1));
        chk("bp_rtrn_data",  256'(rtrn_data),  256'({64'h5151_5151_0000_0000, 64'h5050_5050_0000_0000}));
        chk("bp_r_ready_5",  256'(r_ready),    256'(1'b0));
        rtrn_ready = 1'b1;
        tick();
        chk("bp_drain", 256'(rtrn_valid), 256'(1'b0));
        r_data = 64'h9191_0000_0000_9191; r_last = 1'b1;
        tick();
        r_valid = 1'b0; r_last = 1'b0;
        chk("bp_q_valid", 256'(rtrn_valid), 256'(1'b1));
        chk("bp_q_data",  256'(rtrn_data),  256'({64'h9191_0000_0000_9191, 64'h9090_0000_0000_9090}));
        chk("bp_q_tid",   256'(rtrn_tid),   256'(2'd2));
        tick();

        // AR stall keeps the request stable and blocks new requests
        ar_ready = 1'b0;
        req(56'h9008, 1'b0, 2'd0);
        chk("ars_addr0", 256'(ar_addr), 256'(64'h9000));
        req_valid = 1'b1; req_paddr = 56'hA000; req_nc = 1'b0; req_tid = 2'd3;
        #1;
        chk("ars_req_ready0", 256'(req_ready), 256'(1'b0));
        repeat (3) tick();
        chk("ars_valid_held", 256'(ar_valid),  256'(1'b1));
        chk("ars_addr_held",  256'(ar_addr),   256'(64'h9000));
        chk("ars_id_held",    256'(ar_id),     256'(4'd0));
        chk("ars_req_ready3", 256'(req_ready), 256'(1'b0));
        ar_ready = 1'b1;
        #1;
        chk("ars_req_ready1", 256'(req_ready), 256'(1'b1));
        tick();
        req_valid = 1'b0;
        chk("ars_addr1", 256'(ar_addr), 256'(64'hA000));
        chk("ars_id1",   256'(ar_id),   256'(4'd1));
        beat(4'd0, 64'h1, 1'b0);
        beat(4'd0, 64'h2, 1'b1);
        chk("ars_rtrn0_tid", 256'(rtrn_tid), 256'(2'd0));
        beat(4'd1, 64'h3, 1'b0);
        beat(4'd1, 64'h4, 1'b1);
        chk("ars_rtrn1_tid",  256'(rtrn_tid),  256'(2'd3));
        chk("ars_rtrn1_data", 256'(rtrn_data), 256'({64'h4, 64'h3}));
        tick();
        chk("ars_idle", 256'(busy), 256'(1'b0));

        // 256-bit line with an error on the second beat
        b_req_valid = 1'b1; b_req_paddr = 56'hA010; b_req_nc = 1'b0; b_req_tid = 2'd1;
        tick();
        b_req_valid = 1'b0;
        chk("err_ar_addr", 256'(b_ar_addr), 256'(64'hA000));
        chk("err_ar_len",  256'(b_ar_len),  256'(8'd3));
        b_beat(64'hF0, 2'b00, 1'b0);
        b_beat(64'hF1, 2'b10, 1'b0);
        b_beat(64'hF2, 2'b00, 1'b0);
        b_beat(64'hF3, 2'b00, 1'b1);
        chk("err_rtrn_valid", 256'(b_rtrn_valid), 256'(1'b1));
        chk("err_rtrn_err",   256'(b_rtrn_err),   256'(1'b1));
        chk("err_rtrn_data",  b_rtrn_data,        {64'hF3, 64'hF2, 64'hF1, 64'hF0});
        chk("err_rtrn_tid",   256'(b_rtrn_tid),   256'(2'd1));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
